// File: rtl/tug_of_war_match_if.sv
// Round-control and indicator bundle between the game top and the reaction-race core.
// The master drives clr/pb and reads results; the core is the slave.
interface tug_of_war_match_if #(
  parameter int N       = 2,
  parameter int SCORE_W = 4
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic                 clr;
  logic [N-1:0]         pb;
  logic                 winrnd;
  logic                 tie;
  logic [IDX_W-1:0]     winner;
  logic [N-1:0]         foul;
  logic                 live;
  logic [N*SCORE_W-1:0] score;
  logic                 match_done;
  logic [IDX_W-1:0]     match_winner;

  modport master (
    output clr, pb,
    input  winrnd, tie, winner, foul, live, score, match_done, match_winner
  );

  modport slave (
    input  clr, pb,
    output winrnd, tie, winner, foul, live, score, match_done, match_winner
  );
endinterface

// File: rtl/tug_of_war_match.sv
// N-player reaction race: arming window with foul detection, first clean rising
// edge wins the round, saturating per-player scores and a match winner flag.
module tug_of_war_match #(
  parameter int N          = 2,
  parameter int ARM_CYCLES = 8,
  parameter int WIN_ROUNDS = 3,
  parameter int SCORE_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  tug_of_war_match_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   ARM_LOAD  = CNT_W'(ARM_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LIVE   = 3'd2,
    S_RESULT = 3'd3,
    S_MATCH  = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N-1:0]       r_pb_q;
  logic [N-1:0]       r_foul;
  logic               r_tie;
  logic               r_winrnd;
  logic               r_live;
  logic [IDX_W-1:0]   r_winner;
  logic               r_match_done;
  logic [IDX_W-1:0]   r_match_winner;
  logic [SCORE_W-1:0] r_score [N];

  logic [N-1:0]       w_rise;
  logic [N-1:0]       w_cand;
  logic [N-1:0]       w_foul_arm;
  logic               w_cand_any;
  logic               w_cand_multi;
  logic [IDX_W-1:0]   w_idx;
  logic [SCORE_W-1:0] w_sel_score;
  logic [SCORE_W-1:0] w_inc;

  // Fouled players can never produce a candidate, even after release and re-press.
  always_comb begin
    w_rise       = bus.pb & ~r_pb_q;
    w_cand       = w_rise & ~r_foul;
    w_foul_arm   = r_foul | bus.pb;
    w_cand_any   = |w_cand;
    w_cand_multi = |(w_cand & (w_cand - N'(1)));
    w_idx        = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) w_idx = IDX_W'(i);
    end
    w_sel_score  = r_score[w_idx];
    w_inc        = (w_sel_score == SCORE_MAX) ? w_sel_score : w_sel_score + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_pb_q         <= '0;
      r_foul         <= '0;
      r_tie          <= 1'b0;
      r_winrnd       <= 1'b0;
      r_live         <= 1'b0;
      r_winner       <= '0;
      r_match_done   <= 1'b0;
      r_match_winner <= '0;
      for (int i = 0; i < N; i++) r_score[i] <= '0;
    end else begin
      r_pb_q   <= bus.pb;
      r_winrnd <= 1'b0;
      if (bus.clr) begin
        // clr restarts arming from any state; leaving MATCH also wipes the scores.
        r_state <= S_ARM;
        r_cnt   <= ARM_LOAD;
        r_foul  <= '0;
        r_tie   <= 1'b0;
        r_live  <= 1'b0;
        if (r_state == S_MATCH) begin
          r_match_done <= 1'b0;
          for (int i = 0; i < N; i++) r_score[i] <= '0;
        end
      end else begin
        case (r_state)
          S_ARM: begin
            r_foul <= w_foul_arm;
            if (r_cnt == '0) begin
              if (&w_foul_arm) begin
                r_state <= S_RESULT;
                r_tie   <= 1'b1;
              end else begin
                r_state <= S_LIVE;
                r_live  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_LIVE: begin
            if (w_cand_any) begin
              r_live  <= 1'b0;
              r_state <= S_RESULT;
              if (w_cand_multi) begin
                r_tie <= 1'b1;
              end else begin
                r_winner        <= w_idx;
                r_winrnd        <= 1'b1;
                r_score[w_idx]  <= w_inc;
                if (w_inc == WIN_VAL) begin
                  r_state        <= S_MATCH;
                  r_match_done   <= 1'b1;
                  r_match_winner <= w_idx;
                end
              end
            end
          end
          S_IDLE, S_RESULT, S_MATCH: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_score
      assign bus.score[gi*SCORE_W +: SCORE_W] = r_score[gi];
    end
  endgenerate

  assign bus.winrnd       = r_winrnd;
  assign bus.tie          = r_tie;
  assign bus.winner       = r_winner;
  assign bus.foul         = r_foul;
  assign bus.live         = r_live;
  assign bus.match_done   = r_match_done;
  assign bus.match_winner = r_match_winner;
endmodule

// File: doc/tug_of_war_match.md
# tug_of_war_match

Parametrised N-player reaction-race core for the tug-of-war game. After each `clr` it runs an arming window in which presses are fouls, then awards the round to the first clean rising edge. Simultaneous first presses give a tie. It keeps a saturating per-player round score and flags the match winner at `WIN_ROUNDS`. It replaces the fixed two-button round logic under `top` and drives the round/tie/winner indicators and score display.

## Interface
- `N`, 2: number of players, 2..8.
- `ARM_CYCLES`, 8: length of the arming window in clocks, ≥1.
- `WIN_ROUNDS`, 3: rounds needed to win the match, 1..2^SCORE_W−1.
- `SCORE_W`, 4: width of each score counter.
- `IDX_W` (localparam): max(1, clog2(N)).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `clr` in 1: start a new round, or abort the current one; level-sampled.
- `pb` in N: player buttons. Already clean and synchronous to `clk`.
- `winrnd` out 1: one-cycle pulse when a round is decided with a single winner.
- `tie` out 1: round ended in a tie; held until the next round starts.
- `winner` out IDX_W: index of the last round winner; held.
- `foul` out N: sticky mask of players who pressed during arming; cleared at round start.
- `live` out 1: high while in LIVE.
- `score` out N*SCORE_W: packed scores; player i is at [i*SCORE_W +: SCORE_W].
- `match_done` out 1: a player has reached `WIN_ROUNDS`; held.
- `match_winner` out IDX_W: index of the player who won the match; valid while `match_done`=1.

## Operation
- Edge detect: `pb_q` holds the previous-cycle `pb`. `rise = pb & ~pb_q`.
- FSM states: IDLE, ARM, LIVE, RESULT, MATCH.
- Reset (`rst`=0):
  - State goes to IDLE.
  - All outputs, scores and `pb_q` go to 0.
- IDLE:
  - `clr`=1 → ARM.
  - The arm counter loads ARM_CYCLES−1.
  - `foul` and `tie` clear.
- ARM:
  - Any `pb[i]`=1 (level, not edge) sets `foul[i]`.
  - The counter decrements each cycle.
  - On the cycle the counter equals 0:
    - If all bits of `foul` (including this cycle's update) are 1 → RESULT with `tie`=1 and no score.
    - Otherwise → LIVE.
- LIVE:
  - `cand = rise & ~foul`.
  - Exactly one bit set → RESULT:
    - `winner` = its index.
    - `winrnd` pulses.
    - That player's score increments.
  - Two or more bits set → RESULT with `tie`=1. No score, `winner` unchanged.
  - No timeout; LIVE waits indefinitely.
- RESULT:
  - Outputs hold.
  - `clr`=1 → ARM (same load and clear as from IDLE).
  - Transition to MATCH is handled at the deciding edge (see Score).
- Score:
  - Saturates at 2^SCORE_W−1.
  - If the incremented score equals `WIN_ROUNDS`, the FSM goes directly to MATCH instead of RESULT, at the same edge:
    - `match_done`=1.
    - `match_winner` = winner.
- MATCH:
  - `clr`=1 → ARM.
  - All scores zero, and `match_done` clears, at the same edge.
- `clr` has priority over all other events in every non-reset state:
  - `clr` in ARM or LIVE aborts the round, reloads the counter, clears `foul` and restarts ARM.
  - No score change.
- `rst` has priority over `clr`.

## Timing
- A press driven after edge k−1 is sampled at edge k.
- `winrnd`, `winner`, `tie`, the score update and `match_done` are all visible after edge k. `winrnd` is high for exactly one cycle.
- ARM lasts exactly ARM_CYCLES cycles after the `clr` edge. `live`=1 starting on cycle ARM_CYCLES+1.
- A button held from ARM into LIVE produces no rise, and is already fouled.
- A release followed by a re-press in LIVE by a fouled player is ignored.
- `clr` held high for several cycles keeps re-entering ARM. Arming effectively starts on the last `clr` cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- N=2, ARM_CYCLES=8, WIN_ROUNDS=3:
  - Reset, then `clr` for 1 cycle.
  - `pb`=2'b10 rises 10 cycles later, in LIVE.
  - Expect `winrnd` 1-cycle pulse, `winner`=1, `score[1]`=1, `tie`=0.
- Same setup, `clr`, then `pb`=2'b11 rising in the same LIVE cycle.
  - Expect `tie`=1, `winrnd`=0, scores unchanged.
- `clr`, then `pb[0]` high during cycle 3 of ARM and released, then `pb[0]` rises in LIVE, then `pb[1]` rises.
  - Expect `foul`=2'b01.
  - `pb[0]`'s LIVE rise is ignored.
  - `winner`=1 on the `pb[1]` rise.
- Both buttons held through all of ARM.
  - Expect `foul`=2'b11, `tie`=1 at the end of ARM, LIVE never entered.
- Player 0 wins three consecutive rounds.
  - Expect `match_done`=1 and `match_winner`=0 after the third win.
  - Next `clr` → scores 0, `match_done`=0, state ARM.
- `rst`=0 asserted mid-LIVE with `score[0]`=2.
  - Expect all outputs 0 and IDLE on the next cycle.
  - A `clr` simultaneous with `rst`=0 is ignored.
